fetch_pc_select: RTL and testbench
==================================

FETCH_PC_SELECT -- requirements
Module: fetch_pc_select

Interface
REQ-001: clk  input  1  rising-edge clock for all state.
REQ-002: rst_n  input  1  asynchronous active-low reset.
REQ-003: F_stall  input  1  hold fetch register and state this cycle.
REQ-004: M_icode  input  4  memory-stage icode.
REQ-005: M_cnd  input  1  memory-stage branch-taken flag.
REQ-006: M_valA  input  64  fall-through PC of a jump in M.
REQ-007: W_icode  input  4  writeback-stage icode.
REQ-008: W_valM  input  64  return address popped by a RET in W.
REQ-009: f_icode  input  4  icode of the instruction at f_pc.
REQ-010: f_valC  input  64  constant word of the instruction at f_pc.
REQ-011: f_valP  input  64  sequential next PC from the PC incrementer.
REQ-012: f_instr_valid  input  1  icode/ifun decode is legal.
REQ-013: f_imem_error  input  1  instruction fetch address out of range.
REQ-014: f_pc  output  64  PC the instruction memory reads this cycle.
REQ-015: F_predPC  output  64  registered predicted PC.
REQ-016: f_state  output  2  fetch state: 0 RUN, 1 RET_WAIT, 2 HALTED, 3 ERROR.
REQ-017: f_fetch_en  output  1  f_icode/f_valC/f_valP are consumed this cycle.

Function
REQ-018: mis = (M_icode==4'h7) & ~M_cnd; rtn = (W_icode==4'h9); corr = mis | rtn.
REQ-019: f_pc SHALL be combinational: M_valA if mis, else W_valM if rtn, else F_predPC; mis has priority over rtn.
REQ-020: f_fetch_en SHALL be 1 when (f_state==RUN or corr) and ~F_stall, or when corr regardless of F_stall.
REQ-021: pred = f_valC if f_icode is 4'h7 (JXX) or 4'h8 (CALL), else f_valP; 64-bit, no wrap detection.
REQ-022: on f_fetch_en, F_predPC SHALL load pred at the next edge; otherwise it holds.
REQ-023: next state on f_fetch_en: ERROR if f_imem_error or ~f_instr_valid; else HALTED if f_icode==4'h0; else RET_WAIT if f_icode==4'h9; else RUN.
REQ-024: f_imem_error SHALL dominate ~f_instr_valid, HALT and RET decode.
REQ-025: without f_fetch_en, f_state SHALL hold.
REQ-026: in RET_WAIT, HALTED and ERROR, F_predPC SHALL hold until corr.
REQ-027: corr SHALL override F_stall, cancelling any pending RET_WAIT, HALTED or ERROR.
REQ-028: mis and rtn in the same cycle SHALL be resolved as mis only; the rtn is ignored.
REQ-029: latency: corr to F_predPC update is one edge; f_pc reflects corr in the same cycle.

Reset
REQ-030: rst_n low SHALL asynchronously set F_predPC=64'h0 and f_state=RUN.
REQ-031: during reset f_pc SHALL equal 64'h0 unless mis or rtn is asserted.
REQ-032: reset deassertion mid-RET_WAIT or HALTED SHALL resume fetch from address 0 in RUN.

Configuration
REQ-033: with FETCH_INSTR_COUNT_EN defined, the block SHALL add output f_instr_count (64-bit).
REQ-034: with FETCH_INSTR_COUNT_EN defined, f_instr_count SHALL reset to 0 and increment by 1 per f_fetch_en edge, wrapping at 2^64.
REQ-035: without FETCH_INSTR_COUNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-036: reset, f_icode=1 (nop), f_valP=1 -> F_predPC=1 after one edge, f_state=RUN.
REQ-037: f_icode=8 (CALL) at PC 0x10, f_valC=0x200 -> F_predPC=0x200.
REQ-038: f_icode=9 (RET) -> f_state=RET_WAIT, F_predPC held 3 cycles; W_icode=9 with W_valM=0x48 -> f_pc=0x48 same cycle, f_state=RUN.
REQ-039: f_icode=7, then M_icode=7, M_cnd=0, M_valA=0x33 with F_stall=1 -> f_pc=0x33, F_predPC=pred of instr at 0x33.
REQ-040: f_icode=0 (HALT) -> HALTED; mis and rtn asserted in the same cycle -> f_pc=M_valA, state leaves HALTED.
REQ-041: f_imem_error=1 with f_icode=0 -> ERROR; F_stall=1 for 2 cycles -> F_predPC and f_state unchanged.

Source files
------------

// File: rtl/fetch_pc_select.sv
// Fetch-stage PC selection: picks the PC sent to instruction memory, predicts the next PC
// and tracks the RUN/RET_WAIT/HALTED/ERROR fetch state. Optional FETCH_INSTR_COUNT_EN adds a fetch counter.
module fetch_pc_select (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        F_stall,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    input  logic [3:0]  f_icode,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic        f_instr_valid,
    input  logic        f_imem_error,
    output logic [63:0] f_pc,
    output logic [63:0] F_predPC,
    output logic [1:0]  f_state,
    output logic        f_fetch_en
`ifdef FETCH_INSTR_COUNT_EN
    ,
    output logic [63:0] f_instr_count
`endif
);

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_ERROR    = 2'd3
    } fstate_e;

    fstate_e     state_q, state_d;
    logic [63:0] pred_pc_q, pred_pc_d;
    logic        mis_s, rtn_s, corr_s;

    // Jumps and calls are predicted taken; everything else falls through.
    function automatic logic [63:0] predict_pc(input logic [3:0]  icode,
                                               input logic [63:0] valc,
                                               input logic [63:0] valp);
        logic [63:0] res;
        case (icode)
            ICODE_JXX, ICODE_CALL: res = valc;
            default:               res = valp;
        endcase
        return res;
    endfunction

    // State and predicted-PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pred_pc_q <= 64'h0;
        end else begin
            state_q   <= state_d;
            pred_pc_q <= pred_pc_d;
        end
    end

    // Next-state and next predicted PC; mispredict/return corrections win over stall.
    always_comb begin
        state_d   = state_q;
        pred_pc_d = pred_pc_q;
        if (f_fetch_en) begin
            pred_pc_d = predict_pc(f_icode, f_valC, f_valP);
            if (f_imem_error || !f_instr_valid) begin
                state_d = ST_ERROR;
            end else begin
                case (f_icode)
                    ICODE_HALT: state_d = ST_HALTED;
                    ICODE_RET:  state_d = ST_RET_WAIT;
                    default:    state_d = ST_RUN;
                endcase
            end
        end else begin
            state_d   = state_q;
            pred_pc_d = pred_pc_q;
        end
    end

    // Output selection; a mispredict in M masks a simultaneous RET in W.
    always_comb begin
        mis_s = (M_icode == ICODE_JXX) && !M_cnd;
        rtn_s = (W_icode == ICODE_RET);
        corr_s = mis_s || rtn_s;
        if (mis_s) begin
            f_pc = M_valA;
        end else if (rtn_s) begin
            f_pc = W_valM;
        end else begin
            f_pc = pred_pc_q;
        end
        f_fetch_en = corr_s || ((state_q == ST_RUN) && !F_stall);
        F_predPC   = pred_pc_q;
        f_state    = state_q;
    end

`ifdef FETCH_INSTR_COUNT_EN
    logic [63:0] count_q;

    // Free-running count of fetched instructions, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 64'h0;
        end else if (f_fetch_en) begin
            count_q <= count_q + 64'd1;
        end else begin
            count_q <= count_q;
        end
    end

    assign f_instr_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_pc_select.sv
// Directed bench for fetch_pc_select: reset, prediction, RET/HALT/ERROR waits and corrections.
module tb_fetch_pc_select;

    logic        clk;
    logic        rst_n;
    logic        F_stall;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        f_instr_valid;
    logic        f_imem_error;
    logic [63:0] f_pc;
    logic [63:0] F_predPC;
    logic [1:0]  f_state;
    logic        f_fetch_en;
`ifdef FETCH_INSTR_COUNT_EN
    logic [63:0] f_instr_count;
`endif

    int errors = 0;
    int checks = 0;

    fetch_pc_select dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .F_stall       (F_stall),
        .M_icode       (M_icode),
        .M_cnd         (M_cnd),
        .M_valA        (M_valA),
        .W_icode       (W_icode),
        .W_valM        (W_valM),
        .f_icode       (f_icode),
        .f_valC        (f_valC),
        .f_valP        (f_valP),
        .f_instr_valid (f_instr_valid),
        .f_imem_error  (f_imem_error),
        .f_pc          (f_pc),
        .F_predPC      (F_predPC),
        .f_state       (f_state),
        .f_fetch_en    (f_fetch_en)
`ifdef FETCH_INSTR_COUNT_EN
        ,
        .f_instr_count (f_instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; F_stall = 1'b0;
        M_icode = 4'h1; M_cnd = 1'b0; M_valA = 64'h0;
        W_icode = 4'h1; W_valM = 64'h0;
        f_icode = 4'h1; f_valC = 64'h0; f_valP = 64'h0;
        f_instr_valid = 1'b1; f_imem_error = 1'b0;
        #2;
        chk("rst_predpc", F_predPC, 64'h0);
        chk("rst_state", {62'd0, f_state}, 64'd0);
        chk("rst_fpc", f_pc, 64'h0);
        M_icode = 4'h7; M_valA = 64'hAB; #1;
        chk("rst_fpc_mis", f_pc, 64'hAB);
        M_icode = 4'h1;
        tick();
        rst_n = 1'b1;

        // nop at 0 predicts valP
        f_icode = 4'h1; f_valP = 64'h1; #1;
        chk("nop_fetch_en", {63'd0, f_fetch_en}, 64'd1);
        tick();
        chk("nop_predpc", F_predPC, 64'h1);
        chk("nop_state", {62'd0, f_state}, 64'd0);

        // step to 0x10 then CALL
        f_valP = 64'h10; tick();
        f_icode = 4'h8; f_valC = 64'h200; f_valP = 64'h1A; #1;
        chk("call_fpc", f_pc, 64'h10);
        tick();
        chk("call_predpc", F_predPC, 64'h200);

        // RET waits three cycles, then W return
        f_icode = 4'h9; f_valP = 64'h201; tick();
        chk("ret_state", {62'd0, f_state}, 64'd1);
        chk("ret_predpc", F_predPC, 64'h201);
        f_icode = 4'h1; f_valP = 64'h999; #1;
        chk("ret_no_fetch", {63'd0, f_fetch_en}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ret_hold_pc", F_predPC, 64'h201);
            chk("ret_hold_state", {62'd0, f_state}, 64'd1);
        end
        W_icode = 4'h9; W_valM = 64'h48; f_valP = 64'h49; #1;
        chk("rtn_fpc", f_pc, 64'h48);
        chk("rtn_fetch_en", {63'd0, f_fetch_en}, 64'd1);
        tick();
        chk("rtn_predpc", F_predPC, 64'h49);
        chk("rtn_state", {62'd0, f_state}, 64'd0);
        W_icode = 4'h1;

        // JXX predicted taken, then mispredict under stall
        f_icode = 4'h7; f_valC = 64'h500; f_valP = 64'h52; tick();
        chk("jxx_predpc", F_predPC, 64'h500);
        F_stall = 1'b1; M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h33;
        f_icode = 4'h1; f_valP = 64'h34; #1;
        chk("mis_fpc", f_pc, 64'h33);
        chk("mis_fetch_en", {63'd0, f_fetch_en}, 64'd1);
        tick();
        chk("mis_predpc", F_predPC, 64'h34);
        M_icode = 4'h7; M_cnd = 1'b1; f_valP = 64'h77; #1;
        chk("taken_no_corr_fetch", {63'd0, f_fetch_en}, 64'd0);
        tick();
        chk("stall_hold_pc", F_predPC, 64'h34);
        M_icode = 4'h1; M_cnd = 1'b0; F_stall = 1'b0;

        // HALT, then mis+rtn together resolves as mis
        f_icode = 4'h0; f_valP = 64'h35; tick();
        chk("halt_state", {62'd0, f_state}, 64'd2);
        chk("halt_predpc", F_predPC, 64'h35);
        M_icode = 4'h7; M_valA = 64'h60; W_icode = 4'h9; W_valM = 64'h90;
        f_icode = 4'h1; f_valP = 64'h61; #1;
        chk("both_fpc", f_pc, 64'h60);
        tick();
        chk("both_state", {62'd0, f_state}, 64'd0);
        chk("both_predpc", F_predPC, 64'h61);
        M_icode = 4'h1; W_icode = 4'h1;

        // imem error dominates HALT; stall holds ERROR
        f_imem_error = 1'b1; f_icode = 4'h0; f_valP = 64'h62; tick();
        chk("err_state", {62'd0, f_state}, 64'd3);
        chk("err_predpc", F_predPC, 64'h62);
        f_imem_error = 1'b0; F_stall = 1'b1; f_icode = 4'h1; f_valP = 64'h88;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("err_hold_pc", F_predPC, 64'h62);
            chk("err_hold_state", {62'd0, f_state}, 64'd3);
        end
        F_stall = 1'b0; tick();
        chk("err_nostall_hold", F_predPC, 64'h62);

        // invalid decode dominates RET
        W_icode = 4'h9; W_valM = 64'h100; f_instr_valid = 1'b0; f_icode = 4'h9; f_valP = 64'h102; tick();
        chk("inv_state", {62'd0, f_state}, 64'd3);
        chk("inv_predpc", F_predPC, 64'h102);
        f_instr_valid = 1'b1; f_valP = 64'h202; tick();
        chk("ret2_state", {62'd0, f_state}, 64'd1);
        W_icode = 4'h1;

        // async reset in RET_WAIT resumes at 0 in RUN
        #2 rst_n = 1'b0; #1;
        chk("areset_state", {62'd0, f_state}, 64'd0);
        chk("areset_predpc", F_predPC, 64'h0);
        tick();
        rst_n = 1'b1; f_icode = 4'h1; f_valP = 64'h4; #1;
        chk("resume_fpc", f_pc, 64'h0);
        tick();
        chk("resume_predpc", F_predPC, 64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
